// File: rtl/conv_mode_ctrl.sv
// conv_mode_ctrl
//   Frame-synchronous blur mode controller for conv_kernel. Debounces the
//   two board keys, keeps a requested mode, and commits it to the kernel
//   only at the start of vertical sync so every frame uses one mode.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synchronized key level must hold to be accepted
//   AUTO_FRAMES      frames between automatic mode advances (auto build only)
//
// Ports
//   clk            pixel clock
//   rst            synchronous reset, active-high
//   key_mode_ni    mode-advance key, active-low, asynchronous
//   key_bypass_ni  bypass-toggle key, active-low, asynchronous
//   vs_ni          vertical sync, active-low
//   blur_en        kernel enable (active mode != OFF)
//   blur_sel       kernel select (active mode == BLUR11)
//   mode_o         active mode: 0 OFF, 1 BLUR3, 2 BLUR11
//   pending_o      requested mode differs from active mode
//   frame_cnt_o    count of vs_ni falling edges, wraps at 16 bits
//
// Build option
//   CONV_CTRL_AUTO_CYCLE_EN  when defined, the mode advances by itself every
//                            AUTO_FRAMES frames without key activity.

module conv_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode_ni,
  input  logic        key_bypass_ni,
  input  logic        vs_ni,
  output logic        blur_en,
  output logic        blur_sel,
  output logic [1:0]  mode_o,
  output logic        pending_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BLUR3  = 2'd1;
  localparam logic [1:0] MODE_BLUR11 = 2'd2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_APPLY   = 2'd2;

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Key path: index 0 = mode key, index 1 = bypass key.
  // ---------------------------------------------------------------------
  logic [1:0]    keys;
  logic [1:0]    sync1, sync2, stable, press;
  logic [CW-1:0] db_cnt [2];

  assign keys = {key_bypass_ni, key_mode_ni};

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <=, so each flop samples the values from
    // before the edge and the synchronizer chain really is two stages deep.
    if (rst) begin
      // NOTE: the counter array is reset element by element; it is a handful
      // of flops, not a RAM, so a synchronous clear costs nothing special.
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      press  <= '0;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      press <= '0;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          stable[k] <= sync2[k];
          db_cnt[k] <= '0;
          // Only a 1->0 stable transition is a press; release is silent.
          press[k]  <= stable[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Vertical sync edge and frame counter.
  // ---------------------------------------------------------------------
  logic        vs_d;
  logic        vs_edge;
  logic [15:0] frame_cnt;

  assign vs_edge     = vs_d & ~vs_ni;
  assign frame_cnt_o = frame_cnt;

  // ---------------------------------------------------------------------
  // Optional unattended mode cycling.
  // ---------------------------------------------------------------------
  logic auto_mode;

`ifdef CONV_CTRL_AUTO_CYCLE_EN
  localparam int            AW        = $clog2(AUTO_FRAMES + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

  logic [AW-1:0] auto_cnt;
  logic          auto_ev;
  logic          key_ev;

  assign key_ev = press[0] | press[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_cnt <= '0;
      auto_ev  <= 1'b0;
    end else begin
      auto_ev <= 1'b0;
      if (key_ev) begin
        auto_cnt <= '0;
      end else if (vs_edge) begin
        if (auto_cnt == AUTO_LAST) begin
          auto_cnt <= '0;
          auto_ev  <= 1'b1;
        end else begin
          auto_cnt <= auto_cnt + AW'(1);
        end
      end
    end
  end

  // A real key press in the same cycle takes precedence.
  assign auto_mode = auto_ev & ~key_ev;
`else
  // AUTO_FRAMES is a non-negative frame count, so this is a constant 0; it is
  // referenced only so both builds share one parameter list.
  assign auto_mode = (AUTO_FRAMES < 0);
`endif

  // ---------------------------------------------------------------------
  // Requested mode.
  // ---------------------------------------------------------------------
  logic [1:0] req, last_on, active;
  logic       mode_ev;

  assign mode_ev = press[0] | auto_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      req     <= MODE_OFF;
      last_on <= MODE_BLUR3;
    end else if (press[1]) begin
      // Bypass wins over a same-cycle mode event.
      if (req != MODE_OFF) begin
        last_on <= req;
        req     <= MODE_OFF;
      end else begin
        req <= last_on;
      end
    end else if (mode_ev) begin
      case (req)
        MODE_OFF:   req <= MODE_BLUR3;
        MODE_BLUR3: req <= MODE_BLUR11;
        default:    req <= MODE_OFF;
      endcase
    end
  end

  assign pending_o = (req != active);

  // ---------------------------------------------------------------------
  // Commit FSM and registered kernel controls.
  // ---------------------------------------------------------------------
  logic [1:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      active    <= MODE_OFF;
      vs_d      <= 1'b1;
      frame_cnt <= '0;
      mode_o    <= MODE_OFF;
      blur_en   <= 1'b0;
      blur_sel  <= 1'b0;
    end else begin
      vs_d <= vs_ni;
      if (vs_edge) frame_cnt <= frame_cnt + 16'd1;

      mode_o   <= active;
      blur_en  <= (active != MODE_OFF);
      blur_sel <= (active == MODE_BLUR11);

      case (state)
        S_IDLE: begin
          if (req != active) state <= S_WAIT_VS;
        end
        S_WAIT_VS: begin
          // A request that returns to the active mode is cancelled.
          if (req == active)  state <= S_IDLE;
          else if (vs_edge)   state <= S_APPLY;
        end
        S_APPLY: begin
          active <= req;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mode_ctrl.sv
module tb_conv_mode_ctrl;

  localparam int D  = 4;
  localparam int AF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_mode_ni = 1'b1;
  logic        key_bypass_ni = 1'b1;
  logic        vs_ni = 1'b1;
  logic        blur_en, blur_sel, pending_o;
  logic [1:0]  mode_o;
  logic [15:0] frame_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  conv_mode_ctrl #(.DEBOUNCE_CYCLES(D), .AUTO_FRAMES(AF)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_mode_ni  (key_mode_ni),
    .key_bypass_ni(key_bypass_ni),
    .vs_ni        (vs_ni),
    .blur_en      (blur_en),
    .blur_sel     (blur_sel),
    .mode_o       (mode_o),
    .pending_o    (pending_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // -----------------------------------------------------------------------
  // Behavioural reference. Keys: a press happens when the synchronized key
  // (raw value two samples back) has differed from the accepted level for
  // the last D samples. Commit: the mode is taken on a vs edge once the
  // request has been outstanding since the previous cycle, outside the
  // turnaround after a previous commit.
  // -----------------------------------------------------------------------
  int         m_req, m_last, m_active, m_mode;
  logic [15:0] m_frame, m_ofs = 16'd0;
  bit         m_vsd;
  bit [D:0]   h_mode, h_byp;
  bit         st_mode, st_byp, p_mode, p_byp;
  bit         prev_diff, prev_commit, prev_apply, a_ev;
  bit         fm, fb, vse, diff, commit, apply, kev, mev;
`ifdef CONV_CTRL_AUTO_CYCLE_EN
  int         a_cnt;
`endif

  function automatic bit settled(input bit [D:0] h, input bit st);
    for (int i = 1; i <= D; i++) if (h[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_req = 0; m_last = 1; m_active = 0; m_mode = 0; m_frame = 16'd0; m_vsd = 1'b1;
      h_mode = '1; h_byp = '1; st_mode = 1'b1; st_byp = 1'b1; p_mode = 1'b0; p_byp = 1'b0;
      prev_diff = 1'b0; prev_commit = 1'b0; prev_apply = 1'b0; a_ev = 1'b0;
`ifdef CONV_CTRL_AUTO_CYCLE_EN
      a_cnt = 0;
`endif
    end else begin
      vse    = m_vsd && !vs_ni;
      kev    = p_mode || p_byp;
      mev    = p_mode || (a_ev && !kev);
      diff   = (m_req != m_active);
      apply  = prev_commit;
      commit = vse && diff && prev_diff && !prev_commit && !prev_apply;
      m_mode = m_active;
      if (apply) m_active = m_req;
      if (p_byp) begin
        if (m_req != 0) begin m_last = m_req; m_req = 0; end
        else m_req = m_last;
      end else if (mev) begin
        m_req = (m_req + 1) % 3;
      end
`ifdef CONV_CTRL_AUTO_CYCLE_EN
      if (kev) begin a_cnt = 0; a_ev = 1'b0; end
      else if (vse && a_cnt == AF - 1) begin a_cnt = 0; a_ev = 1'b1; end
      else begin if (vse) a_cnt++; a_ev = 1'b0; end
`endif
      fm = settled(h_mode, st_mode);
      fb = settled(h_byp, st_byp);
      p_mode = fm && st_mode;
      p_byp  = fb && st_byp;
      if (fm) st_mode = !st_mode;
      if (fb) st_byp = !st_byp;
      h_mode = {h_mode[D-1:0], key_mode_ni};
      h_byp  = {h_byp[D-1:0], key_bypass_ni};
      if (vse) m_frame = m_frame + 16'd1;
      m_vsd = vs_ni;
      prev_diff = diff; prev_commit = commit; prev_apply = apply;
    end
  end

  // One compare process, every cycle, just after the active edge.
  always @(posedge clk) begin
    logic [15:0] exp_frame;
    #1;
    exp_frame = m_frame + m_ofs;
    check("mode_o",      mode_o,      m_mode);
    check("blur_en",     blur_en,     (m_mode != 0));
    check("blur_sel",    blur_sel,    (m_mode == 2));
    check("pending_o",   pending_o,   (m_req != m_active));
    check("frame_cnt_o", frame_cnt_o, exp_frame);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 1 = mode key, 2 = bypass key, 3 = both in the same cycle
  task automatic press_key(input int which);
    if (which[0]) key_mode_ni = 1'b0;
    if (which[1]) key_bypass_ni = 1'b0;
    cyc(D + 6);
    key_mode_ni = 1'b1;
    key_bypass_ni = 1'b1;
    cyc(D + 4);
  endtask

  // vs low for 3 cycles; returns once the committed mode is visible.
  task automatic vsync();
    vs_ni = 1'b0;
    cyc(3);
    vs_ni = 1'b1;
    cyc(3);
  endtask

  initial begin
    // Reset with vs toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vs_ni = ~vs_ni;
    end
    check("rst_blur_en", blur_en, 0);
    check("rst_blur_sel", blur_sel, 0);
    check("rst_mode", mode_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_frame", frame_cnt_o, 0);
    vs_ni = 1'b1;
    rst = 1'b0;
    cyc(5);

`ifndef CONV_CTRL_AUTO_CYCLE_EN
    // Mode press and commit.
    key_mode_ni = 1'b0;
    cyc(6);
    check("press_pending_c6", pending_o, 0);
    cyc(1);
    check("press_pending_c7", pending_o, 1);
    cyc(3);
    key_mode_ni = 1'b1;
    cyc(D + 4);
    check("press_mode_before_vs", mode_o, 0);
    vs_ni = 1'b0;
    cyc(2);
    check("commit_mode_n2", mode_o, 0);
    cyc(1);
    check("commit_mode_n3", mode_o, 1);
    check("commit_blur_en", blur_en, 1);
    check("commit_blur_sel", blur_sel, 0);
    cyc(2);
    vs_ni = 1'b1;
    cyc(3);

    // Bounce rejection.
    for (int i = 0; i < 5; i++) begin
      key_mode_ni = 1'b0;
      cyc(3);
      key_mode_ni = 1'b1;
      check("bounce_pending", pending_o, 0);
      cyc(3);
    end
    cyc(6);
    check("bounce_pending_end", pending_o, 0);
    check("bounce_mode", mode_o, 1);

    // Bypass restore: 2 -> 0 -> 2.
    press_key(1);
    vsync();
    check("byp_mode_2", mode_o, 2);
    press_key(2);
    check("byp_hold_2", mode_o, 2);
    check("byp_pending", pending_o, 1);
    vsync();
    check("byp_mode_0", mode_o, 0);
    press_key(2);
    check("byp_hold_0", mode_o, 0);
    vsync();
    check("byp_mode_2b", mode_o, 2);

    // Simultaneous presses from BLUR3, then cancel.
    press_key(1);
    vsync();
    press_key(1);
    vsync();
    check("sim_start_mode", mode_o, 1);
    press_key(3);
    check("sim_model_req", m_req, 0);
    check("sim_pending", pending_o, 1);
    press_key(2);
    check("cancel_pending", pending_o, 0);
    vsync();
    check("cancel_mode", mode_o, 1);

    // Request lands in the same cycle as the vs edge: waits a frame.
    key_mode_ni = 1'b0;
    cyc(7);
    vs_ni = 1'b0;
    cyc(3);
    key_mode_ni = 1'b1;
    vs_ni = 1'b1;
    cyc(8);
    check("late_req_mode", mode_o, 1);
    check("late_req_pending", pending_o, 1);
    vsync();
    check("late_req_commit", mode_o, 2);
`else
    // Unattended cycling every AF frames.
    for (int f = 1; f <= 10; f++) begin
      vsync();
      if (f == 3)  check("auto_f3", mode_o, 0);
      if (f == 4)  check("auto_f4", mode_o, 1);
      if (f == 7)  check("auto_f7", mode_o, 2);
      if (f == 10) check("auto_f10", mode_o, 0);
    end
`endif

    // Counter wrap via preload.
    m_ofs = 16'hFFFF - m_frame;
    dut.frame_cnt = 16'hFFFF;
    cyc(1);
    check("wrap_preload", frame_cnt_o, 16'hFFFF);
    vs_ni = 1'b0;
    cyc(1);
    check("wrap_zero", frame_cnt_o, 0);
    vs_ni = 1'b1;
    cyc(3);

    // Randomized traffic with occasional mid-operation reset.
    rst = 1'b1;
    m_ofs = 16'd0;
    cyc(2);
    rst = 1'b0;
    begin
      int km_hold = 0, kb_hold = 0, vs_hold = 20;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        rst = ($urandom_range(0, 1499) == 0);
        if (km_hold == 0) begin
          key_mode_ni = 1'($urandom_range(0, 1));
          km_hold = int'($urandom_range(1, 12));
        end else km_hold--;
        if (kb_hold == 0) begin
          key_bypass_ni = 1'($urandom_range(0, 1));
          kb_hold = int'($urandom_range(1, 12));
        end else kb_hold--;
        if (vs_hold == 0) begin
          if (vs_ni) begin vs_ni = 1'b0; vs_hold = int'($urandom_range(1, 3)); end
          else begin vs_ni = 1'b1; vs_hold = int'($urandom_range(15, 40)); end
        end else vs_hold--;
      end
    end
    rst = 1'b0;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
